step_ex_mov: RTL and testbench

- Generalised register-move execution step for the microsequenced core.
- On an ena_ strobe, copies the source register to the destination register (COPY mode), or exchanges the two (SWAP mode), over a shared tri-stated write-data bus and per-register open-drain write enables.
- Width, register count and the read-only register set are parameters.
- Completion is signalled by a single-cycle rdy_ pulse on the shared ready line.

---
 rtl/step_ex_mov_if.sv | 31 +++
 rtl/step_ex_mov.sv | 178 +++++++++++++++++
 tb/tb_step_ex_mov.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_ex_mov_if.sv
// -----------------------------------------------------------------------------
// step_ex_mov_if
//   Command/status bundle between the microsequencer and the register-move step.
//   Only the actively driven signals live here. The shared open-drain and
//   tri-state lines (rdy_, err_, reg_din, reg_we_) stay plain ports on the step,
//   because they resolve on nets that have other drivers outside it.
//
//   ena_       start strobe, active-low
//   mode       0 = COPY, 1 = SWAP
//   src_id     source register index
//   dst_id     destination register index
//   regs_dout  flattened register read values, register i at [i*W +: W]
//   busy       high while an operation is in flight
// -----------------------------------------------------------------------------
interface step_ex_mov_if #(
    parameter int W     = 8,
    parameter int NREGS = 16,
    parameter int IDW   = 4
);
    logic                 ena_;
    logic                 mode;
    logic [IDW-1:0]       src_id;
    logic [IDW-1:0]       dst_id;
    logic [NREGS*W-1:0]   regs_dout;
    logic                 busy;

    // sequencer / register-file side
    modport master (output ena_, mode, src_id, dst_id, regs_dout, input busy);
    // move step side
    modport slave  (input ena_, mode, src_id, dst_id, regs_dout, output busy);
endinterface

// File: rtl/step_ex_mov.sv
// -----------------------------------------------------------------------------
// step_ex_mov
//   Register-move execution step. On an ena_ strobe it copies src to dst
//   (COPY) or exchanges them (SWAP) over the shared write-data bus, using
//   per-register open-drain write enables. Completion is a one-cycle low
//   pulse on rdy_; err_ is pulled low with it when any write was suppressed
//   (read-only register or index >= NREGS).
//
//   clk      clock, all state changes on posedge
//   rst_     asynchronous active-low reset
//   cmd      step_ex_mov_if.slave: ena_, mode, src_id, dst_id, regs_dout, busy
//   rdy_     shared completion line, 0 or Z
//   err_     shared error line, 0 or Z
//   reg_din  shared write-data bus, Z in IDLE
//   reg_we_  per-register write enables, each bit 0 or Z
// -----------------------------------------------------------------------------
module step_ex_mov #(
    parameter int               W       = 8,
    parameter int               NREGS   = 16,
    parameter int               IDW     = 4,
    parameter logic [NREGS-1:0] RO_MASK = NREGS'(16'h4000)
) (
    input  logic            clk,
    input  logic            rst_,
    step_ex_mov_if.slave    cmd,
    output wire             rdy_,
    output wire             err_,
    output wire [W-1:0]     reg_din,
    output wire [NREGS-1:0] reg_we_
);

    typedef enum logic [2:0] {
        IDLE,
        COPY_DRV,
        COPY_WR,
        SWAP_A_DRV,
        SWAP_A_WR,
        SWAP_B_DRV,
        SWAP_B_WR
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] src_q, src_d;
    logic [IDW-1:0] dst_q, dst_d;
    logic [W-1:0]   tmp_q, tmp_d;
    logic           ro_hit_q, ro_hit_d;

    logic             din_en;
    logic [W-1:0]     din_val;
    logic [NREGS-1:0] we_en;
    logic             rdy_en;
    logic             err_en;

    // Out-of-range indices read as zero.
    function automatic logic [W-1:0] rd_reg(input logic [NREGS*W-1:0] flat,
                                            input logic [IDW-1:0]     idx);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++)
            if (idx == IDW'(i)) v = flat[i*W +: W];
        return v;
    endfunction

    // Writable = in range and not read-only.
    function automatic logic writable(input logic [IDW-1:0] idx);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < NREGS; i++)
            if (idx == IDW'(i)) ok = !RO_MASK[i];
        return ok;
    endfunction

    // One-hot enable; suppressed writes decode to all-zero.
    function automatic logic [NREGS-1:0] we_dec(input logic [IDW-1:0] idx);
        logic [NREGS-1:0] d;
        d = '0;
        for (int i = 0; i < NREGS; i++)
            if (idx == IDW'(i) && !RO_MASK[i]) d[i] = 1'b1;
        return d;
    endfunction

    logic [W-1:0] src_live, dst_live;
    assign src_live = rd_reg(cmd.regs_dout, src_q);
    assign dst_live = rd_reg(cmd.regs_dout, dst_q);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            tmp_q    <= '0;
            ro_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            tmp_q    <= tmp_d;
            ro_hit_q <= ro_hit_d;
        end
    end

    // The mode is carried by the state path itself, so it needs no register.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        tmp_d    = tmp_q;
        ro_hit_d = ro_hit_q;
        din_en   = 1'b0;
        din_val  = '0;
        we_en    = '0;
        rdy_en   = 1'b0;
        err_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!cmd.ena_) begin
                    src_d    = cmd.src_id;
                    dst_d    = cmd.dst_id;
                    tmp_d    = rd_reg(cmd.regs_dout, cmd.src_id);
                    ro_hit_d = 1'b0;
                    state_d  = cmd.mode ? SWAP_A_DRV : COPY_DRV;
                end
            end
            COPY_DRV: begin
                din_en  = 1'b1;
                din_val = src_live;
                state_d = COPY_WR;
            end
            COPY_WR: begin
                din_en  = 1'b1;
                din_val = src_live;
                we_en   = we_dec(dst_q);
                rdy_en  = 1'b1;
                err_en  = !writable(dst_q);
                state_d = IDLE;
            end
            SWAP_A_DRV: begin
                din_en  = 1'b1;
                din_val = dst_live;
                state_d = SWAP_A_WR;
            end
            SWAP_A_WR: begin
                din_en  = 1'b1;
                din_val = dst_live;
                we_en   = we_dec(src_q);
                if (!writable(src_q)) ro_hit_d = 1'b1;
                state_d = SWAP_B_DRV;
            end
            // Second half writes the snapshot, since src may already be overwritten.
            SWAP_B_DRV: begin
                din_en  = 1'b1;
                din_val = tmp_q;
                state_d = SWAP_B_WR;
            end
            SWAP_B_WR: begin
                din_en  = 1'b1;
                din_val = tmp_q;
                we_en   = we_dec(dst_q);
                rdy_en  = 1'b1;
                err_en  = ro_hit_q || !writable(dst_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd.busy = (state_q != IDLE);

    assign rdy_    = rdy_en ? 1'b0 : 1'bz;
    assign err_    = err_en ? 1'b0 : 1'bz;
    assign reg_din = din_en ? din_val : {W{1'bz}};

    for (genvar g = 0; g < NREGS; g++) begin : g_we
        assign reg_we_[g] = we_en[g] ? 1'b0 : 1'bz;
    end

endmodule

// File: tb/tb_step_ex_mov.sv
// -----------------------------------------------------------------------------
// tb_step_ex_mov
//   Two instances: a 16-register step (register 14 read-only) and a 6-register
//   step for out-of-range indices. The shared lines get pull-ups, so a
//   released line reads 1. A behavioural register file applies the write
//   enables. Expected completions are queued by the stimulus; the monitor
//   matches them against each rdy_ pulse.
// -----------------------------------------------------------------------------
module tb_step_ex_mov;
    localparam int W   = 8;
    localparam int N1  = 16;
    localparam int N2  = 6;
    localparam int IDW = 4;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    step_ex_mov_if #(.W(W), .NREGS(N1), .IDW(IDW)) if1 ();
    step_ex_mov_if #(.W(W), .NREGS(N2), .IDW(IDW)) if2 ();

    tri1           rdy1, err1, rdy2, err2;
    tri1 [N1-1:0]  we1;
    tri1 [N2-1:0]  we2;
    wire [W-1:0]   din1, din2;

    step_ex_mov #(.W(W), .NREGS(N1), .IDW(IDW), .RO_MASK(16'h4000)) dut1 (
        .clk(clk), .rst_(rst_), .cmd(if1.slave),
        .rdy_(rdy1), .err_(err1), .reg_din(din1), .reg_we_(we1));

    step_ex_mov #(.W(W), .NREGS(N2), .IDW(IDW), .RO_MASK(6'h00)) dut2 (
        .clk(clk), .rst_(rst_), .cmd(if2.slave),
        .rdy_(rdy2), .err_(err2), .reg_din(din2), .reg_we_(we2));

    // Register file model, with a load port for preloading values.
    logic [W-1:0] regs1 [N1];
    logic [W-1:0] regs2 [N2];
    logic         ld_en  = 1'b0;
    logic         ld_sel = 1'b0;
    int           ld_idx = 0;
    logic [W-1:0] ld_val = '0;

    always @(posedge clk) begin
        for (int i = 0; i < N1; i++) if (we1[i] == 1'b0) regs1[i] <= din1;
        for (int i = 0; i < N2; i++) if (we2[i] == 1'b0) regs2[i] <= din2;
        if (ld_en) begin
            if (ld_sel) regs2[ld_idx] <= ld_val;
            else        regs1[ld_idx] <= ld_val;
        end
    end

    for (genvar g = 0; g < N1; g++) begin : g_rd1
        assign if1.regs_dout[g*W +: W] = regs1[g];
    end
    for (genvar g = 0; g < N2; g++) begin : g_rd2
        assign if2.regs_dout[g*W +: W] = regs2[g];
    end

    // Monitor view of whichever instance is under test.
    logic         sel = 1'b0;
    wire          busy_s = sel ? if2.busy : if1.busy;
    wire          rdy_s  = sel ? rdy2 : rdy1;
    wire          err_s  = sel ? err2 : err1;
    wire [15:0]   we_s   = sel ? {10'h3FF, we2} : we1;
    wire [W-1:0]  din_s  = sel ? din2 : din1;

    typedef struct {
        logic        err;
        int          cyc;
        logic [23:0] wlog;
        int          nwr;
        logic [7:0]  d1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: accumulates cycle count, first-cycle bus value and the write
    // log of the operation in flight, and checks them on the rdy_ pulse.
    int          cyc = 0;
    int          nwr = 0;
    logic        multi = 1'b0;
    logic [23:0] wlog = '0;
    logic [7:0]  d1 = '0;

    always @(negedge clk) begin
        int nlow;
        int idx;
        if (!busy_s) begin
            cyc = 0; nwr = 0; wlog = '0; multi = 1'b0;
        end else begin
            cyc++;
            if (cyc == 1) d1 = din_s;
            nlow = 0;
            idx  = 0;
            for (int i = 0; i < 16; i++)
                if (we_s[i] == 1'b0) begin nlow++; idx = i; end
            if (nlow > 1) multi = 1'b1;
            if (nlow == 1) begin
                wlog = {wlog[11:0], 4'(idx), din_s};
                nwr++;
            end
            if (!rdy_s) begin
                if (q.size() == 0) begin
                    chk("unexpected_rdy", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("err", {31'd0, !err_s}, {31'd0, e.err});
                    chk("latency", cyc, e.cyc);
                    chk("write_log", {8'd0, wlog}, {8'd0, e.wlog});
                    chk("write_count", nwr, e.nwr);
                    chk("din_cycle1", {24'd0, d1}, {24'd0, e.d1});
                    chk("multi_we", {31'd0, multi}, 0);
                end
            end
        end
    end

    task automatic ld(input logic s, input int idx, input logic [W-1:0] v);
        @(negedge clk);
        ld_en = 1'b1; ld_sel = s; ld_idx = idx; ld_val = v;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic start(input logic s, input logic m, input logic [IDW-1:0] src,
                         input logic [IDW-1:0] dst);
        @(negedge clk);
        sel = s;
        if (s) begin
            if2.mode = m; if2.src_id = src; if2.dst_id = dst; if2.ena_ = 1'b0;
        end else begin
            if1.mode = m; if1.src_id = src; if1.dst_id = dst; if1.ena_ = 1'b0;
        end
        @(negedge clk);
        if1.ena_ = 1'b1;
        if2.ena_ = 1'b1;
    endtask

    task automatic run(input logic s, input logic m, input logic [IDW-1:0] src,
                       input logic [IDW-1:0] dst, input logic e_err, input int e_cyc,
                       input logic [23:0] e_wlog, input int e_nwr, input logic [7:0] e_d1);
        exp_t e;
        e.err = e_err; e.cyc = e_cyc; e.wlog = e_wlog; e.nwr = e_nwr; e.d1 = e_d1;
        q.push_back(e);
        start(s, m, src, dst);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((q.size() != 0 || busy_s) && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0 || busy_s) begin
            chk("timeout", 1, 0);
            q.delete();
        end
    endtask

    task automatic chk_reg(input logic s, input int idx, input logic [W-1:0] v);
        logic [W-1:0] a;
        a = s ? regs2[idx] : regs1[idx];
        chk($sformatf("reg%0d_%0d", s, idx), {24'd0, a}, {24'd0, v});
    endtask

    initial begin
        if1.ena_ = 1'b1; if1.mode = 1'b0; if1.src_id = '0; if1.dst_id = '0;
        if2.ena_ = 1'b1; if2.mode = 1'b0; if2.src_id = '0; if2.dst_id = '0;
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, if1.busy}, 0);
        chk("rst_rdy", {31'd0, rdy1}, 1);
        chk("rst_err", {31'd0, err1}, 1);
        chk("rst_we", {16'd0, we1}, 32'hFFFF);

        // COPY 3 -> 7
        ld(0, 3, 8'h5A); ld(0, 7, 8'h00);
        run(0, 0, 4'd3, 4'd7, 0, 2, 24'h00075A, 1, 8'h5A);
        wait_done();
        chk_reg(0, 7, 8'h5A);
        chk("idle_we", {16'd0, we1}, 32'hFFFF);
        chk("idle_rdy", {31'd0, rdy1}, 1);

        // SWAP 1 <-> 2
        ld(0, 1, 8'h11); ld(0, 2, 8'h22);
        run(0, 1, 4'd1, 4'd2, 0, 4, 24'h122211, 2, 8'h22);
        wait_done();
        chk_reg(0, 1, 8'h22);
        chk_reg(0, 2, 8'h11);

        // COPY into read-only 14
        ld(0, 0, 8'h3C); ld(0, 14, 8'hFF);
        run(0, 0, 4'd0, 4'd14, 1, 2, 24'h000000, 0, 8'h3C);
        wait_done();
        chk_reg(0, 14, 8'hFF);

        // SWAP with read-only source 14
        ld(0, 5, 8'h33);
        run(0, 1, 4'd14, 4'd5, 1, 4, 24'h0005FF, 1, 8'h33);
        wait_done();
        chk_reg(0, 5, 8'hFF);
        chk_reg(0, 14, 8'hFF);

        // SWAP 1 <-> 2 again with ena_ re-asserted in cycle 2
        run(0, 1, 4'd1, 4'd2, 0, 4, 24'h111222, 2, 8'h11);
        @(negedge clk); if1.ena_ = 1'b0;
        @(negedge clk); if1.ena_ = 1'b1;
        wait_done();
        repeat (6) @(negedge clk);
        chk("no_restart_busy", {31'd0, if1.busy}, 0);
        chk_reg(0, 1, 8'h11);
        chk_reg(0, 2, 8'h22);

        // Reset in SWAP_B_DRV: src already written, dst must not be
        ld(0, 3, 8'h5A); ld(0, 4, 8'h44);
        start(0, 1, 4'd3, 4'd4);
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        chk("abort_busy", {31'd0, if1.busy}, 0);
        chk("abort_rdy", {31'd0, rdy1}, 1);
        chk("abort_err", {31'd0, err1}, 1);
        chk("abort_we", {16'd0, we1}, 32'hFFFF);
        @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        chk_reg(0, 4, 8'h44);
        chk_reg(0, 3, 8'h44);

        // SWAP with src == dst
        ld(0, 6, 8'h66);
        run(0, 1, 4'd6, 4'd6, 0, 4, 24'h666666, 2, 8'h66);
        wait_done();
        chk_reg(0, 6, 8'h66);

        // 6-register instance: out-of-range destination, then source
        ld(1, 1, 8'hAB);
        run(1, 0, 4'd1, 4'd9, 1, 2, 24'h000000, 0, 8'hAB);
        wait_done();
        chk_reg(1, 1, 8'hAB);
        ld(1, 2, 8'h77);
        run(1, 0, 4'd9, 4'd2, 0, 2, 24'h000200, 1, 8'h00);
        wait_done();
        chk_reg(1, 2, 8'h00);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
